host_board: RTL and testbench



---
 rtl/host_pkg.sv | 26 ++
 rtl/uart_tx_8n1.sv | 101 ++++++++++
 rtl/host_board.sv | 79 +++++++
 tb/tb_host_board.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_pkg.sv
// Shared types and constants for the host board: banner ROM contents and FSM state encodings.
package host_pkg;

    localparam int MSG_LEN_DEF = 15;

    // "Hello, World!\r\n", byte 0 goes out first
    localparam logic [7:0] BANNER [0:MSG_LEN_DEF-1] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
        8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A
    };

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        IDLE_START,
        LOAD,
        SEND,
        DONE
    } seq_state_t;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter, CLKS_PER_BIT cycles per bit, tx registered; a start seen on the done
// cycle launches the next frame on the following edge so frames run back-to-back with no gap.
module uart_tx_8n1
    import host_pkg::*;
#(
    parameter int CLKS_PER_BIT = 43
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done    = 1'b0;
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    shift_d = data;
                    baud_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done = 1'b1;
                    if (start) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        shift_d = data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: rtl/host_board.sv
// Sends the banner once over 8N1 serial after each reset release, then holds the line high.
// First start bit on the second edge after release; no flow control, bytes leave back-to-back.
module host_board
    import host_pkg::*;
#(
    parameter int CLKS_PER_BIT = 43,
    parameter int MSG_LEN      = MSG_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic uart_tx
);

    localparam int               IDX_W    = $clog2(MSG_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

    seq_state_t       seq_q, seq_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] byte_sel;
    logic             tx_start;
    logic             tx_busy;
    logic             tx_done;
    logic [7:0]       tx_data;

    // The next byte is handed over on the done cycle itself; LOAD only launches a frame
    // when the transmitter is idle, which is the case just after reset.
    always_comb begin
        seq_d    = seq_q;
        index_d  = index_q;
        byte_sel = index_q;
        tx_start = 1'b0;
        case (seq_q)
            IDLE_START: seq_d = LOAD;
            LOAD: begin
                tx_start = !tx_busy;
                seq_d    = SEND;
            end
            SEND: begin
                if (tx_done) begin
                    if (index_q == IDX_LAST) begin
                        seq_d = DONE;
                    end else begin
                        index_d  = index_q + IDX_W'(1);
                        byte_sel = index_d;
                        tx_start = 1'b1;
                        seq_d    = LOAD;
                    end
                end
            end
            DONE:    seq_d = DONE;
            default: seq_d = IDLE_START;
        endcase
    end

    assign tx_data = BANNER[byte_sel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q   <= IDLE_START;
            index_q <= '0;
        end else begin
            seq_q   <= seq_d;
            index_q <= index_d;
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (tx_start),
        .data  (tx_data),
        .tx    (uart_tx),
        .busy  (tx_busy),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_host_board.sv
// Directed bench for host_board: default baud instance plus a CLKS_PER_BIT=4 instance on a shared reset.
module tb_host_board;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic sel_fast = 1'b0;
    logic tx_slow, tx_fast;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rel0   = 0;

    logic [7:0] rx_q[$];
    int         rx_st[$];
    int         rx_ferr;

    logic [7:0] exp_msg [15] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
                                 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    host_board #(.CLKS_PER_BIT(43), .MSG_LEN(15)) dut_slow (
        .clk     (clk),
        .reset   (reset),
        .uart_tx (tx_slow)
    );

    host_board #(.CLKS_PER_BIT(4), .MSG_LEN(15)) dut_fast (
        .clk     (clk),
        .reset   (reset),
        .uart_tx (tx_fast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic line();
        return sel_fast ? tx_fast : tx_slow;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release on a falling edge; the next rising edge is edge 1 (cyc - rel0 == 1 after it).
    task automatic apply_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        rel0  = cyc;
    endtask

    task automatic wait_rel(input int target);
        while (cyc - rel0 < target) step();
    endtask

    // Mid-bit sampling receiver; stops looking for start bits once the relative limit is reached.
    task automatic uart_rx(input int cpb, input int limit);
        logic [7:0] b;
        rx_q.delete();
        rx_st.delete();
        rx_ferr = 0;
        while (cyc - rel0 < limit) begin
            step();
            if (line() === 1'b0) begin
                rx_st.push_back(cyc - rel0);
                repeat (cpb / 2) step();
                if (line() !== 1'b0) rx_ferr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (cpb) step();
                    b[i] = line();
                end
                repeat (cpb) step();
                if (line() !== 1'b1) rx_ferr++;
                repeat (cpb - cpb / 2 - 1) step();
                rx_q.push_back(b);
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx_slow !== 1'b1 || tx_fast !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d low samples during reset, expected 0", bad);
        end
        reset = 1'b0;
        rel0  = cyc;
        step();
        checks++;
        if (tx_slow !== 1'b1) begin
            errors++;
            $display("FAIL edge1_idle: uart_tx=%b expected 1", tx_slow);
        end
        step();
        checks++;
        if (tx_slow !== 1'b0) begin
            errors++;
            $display("FAIL edge2_start_slow: uart_tx=%b expected 0", tx_slow);
        end
        checks++;
        if (tx_fast !== 1'b0) begin
            errors++;
            $display("FAIL edge2_start_fast: uart_tx=%b expected 0", tx_fast);
        end
    endtask

    // Continues straight from test_reset: byte 0 started at edge 2.
    task automatic test_byte0();
        logic [9:0] s;
        for (int i = 0; i < 10; i++) begin
            wait_rel(2 + 21 + 43 * i);
            s[i] = tx_slow;
        end
        checks++;
        if (s[0] !== 1'b0) begin
            errors++;
            $display("FAIL byte0_start: got %b expected 0", s[0]);
        end
        checks++;
        if (s[8:1] !== 8'h48) begin
            errors++;
            $display("FAIL byte0_data: got %h expected 48", s[8:1]);
        end
        checks++;
        if (s[9] !== 1'b1) begin
            errors++;
            $display("FAIL byte0_stop: got %b expected 1", s[9]);
        end
    endtask

    task automatic test_full_line();
        int bad = 0;
        logic [7:0] got;
        sel_fast = 1'b0;
        apply_reset(10);
        uart_rx(43, 6950);
        checks++;
        if (rx_q.size() != 15) begin
            errors++;
            $display("FAIL line_count: got %0d bytes expected 15", rx_q.size());
        end
        for (int k = 0; k < 15; k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            checks++;
            if (got !== exp_msg[k]) begin
                errors++;
                $display("FAIL line_byte%0d: got %h expected %h", k, got, exp_msg[k]);
            end
        end
        checks++;
        if (rx_ferr != 0) begin
            errors++;
            $display("FAIL line_framing: %0d bad start/stop samples, expected 0", rx_ferr);
        end
        for (int k = 0; k < rx_st.size(); k++) if (rx_st[k] != 2 + 430 * k) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL line_spacing: %0d starts off the 430-cycle grid, expected 0", bad);
        end
        bad = 0;
        repeat (10000) begin
            step();
            if (tx_slow !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL line_idle_after: %0d low samples, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        sel_fast = 1'b0;
        apply_reset(10);
        wait_rel(2 + 5 * 430 + 43 + 15);
        checks++;
        if (tx_slow !== 1'b0) begin
            errors++;
            $display("FAIL mid_byte5_bit0: uart_tx=%b expected 0", tx_slow);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (tx_slow !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_reset: uart_tx=%b expected 1", tx_slow);
        end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        rel0  = cyc;
        uart_rx(43, 6950);
        checks++;
        if (rx_q.size() != 15) begin
            errors++;
            $display("FAIL mid_count: got %0d bytes expected 15", rx_q.size());
        end
        checks++;
        if (rx_q.size() == 0 || rx_q[0] !== 8'h48) begin
            errors++;
            $display("FAIL mid_first_byte: got %h expected 48", (rx_q.size() != 0) ? rx_q[0] : 8'hxx);
        end
        checks++;
        if (rx_st.size() == 0 || rx_st[0] != 2) begin
            errors++;
            $display("FAIL mid_restart_edge: got %0d expected 2", (rx_st.size() != 0) ? rx_st[0] : -1);
        end
    endtask

    task automatic test_fast_baud();
        int bad = 0;
        sel_fast = 1'b1;
        apply_reset(10);
        uart_rx(4, 700);
        checks++;
        if (rx_q.size() != 15) begin
            errors++;
            $display("FAIL fast_count: got %0d bytes expected 15", rx_q.size());
        end
        for (int k = 0; k < 15; k++) begin
            if (k >= rx_q.size() || rx_q[k] !== exp_msg[k]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fast_content: %0d wrong bytes, expected 0", bad);
        end
        checks++;
        if (rx_ferr != 0) begin
            errors++;
            $display("FAIL fast_framing: %0d bad start/stop samples, expected 0", rx_ferr);
        end
        checks++;
        if (rx_st.size() != 15 || rx_st[0] != 2 || rx_st[14] != 562) begin
            errors++;
            $display("FAIL fast_timing: first/last start %0d/%0d expected 2/562",
                     (rx_st.size() > 0) ? rx_st[0] : -1, (rx_st.size() > 14) ? rx_st[14] : -1);
        end
        sel_fast = 1'b0;
    endtask

    // Every completed run of constant level on the line must be a whole number of bit times.
    task automatic test_bit_widths(input logic fast, input int cpb, input int limit);
        int   bad = 0;
        int   nruns = 0;
        int   run = 0;
        bit   started = 1'b0;
        logic prev;
        sel_fast = fast;
        apply_reset(10);
        step();
        prev = line();
        while (cyc - rel0 < limit) begin
            step();
            if (line() !== prev) begin
                if (started) begin
                    nruns++;
                    if (run % cpb != 0) bad++;
                end
                started = 1'b1;
                run     = 1;
                prev    = line();
            end else begin
                run++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL widths_cpb%0d: %0d runs not a multiple of %0d", cpb, bad, cpb);
        end
        checks++;
        if (nruns < 15) begin
            errors++;
            $display("FAIL widths_runs_cpb%0d: saw %0d runs, expected at least 15", cpb, nruns);
        end
        sel_fast = 1'b0;
    endtask

    initial begin
        test_reset();
        test_byte0();
        test_full_line();
        test_reset_mid_frame();
        test_fast_baud();
        test_bit_widths(1'b1, 4, 700);
        test_bit_widths(1'b0, 43, 6600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
